l2cache_plru_replace: RTL
=========================

L2CACHE_PLRU_REPLACE -- requirements
Module: l2cache_plru_replace

Interface
REQ-001 SHALL have parameter addr_width, default 4, set-index width (sets = 2^addr_width).
REQ-002 SHALL have parameter way, default 8; only the value 8 is supported (3-level PLRU tree, 7 bits per set).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port lookup_valid  input  1  tag lookup issued to the TagV array this cycle.
REQ-006 SHALL have port lookup_index  input  addr_width  set index of the lookup.
REQ-007 SHALL have port hit  input  8  per-way hit from TagV, valid the cycle after lookup_valid.
REQ-008 SHALL have port valid  input  8  per-way valid from TagV, same timing as hit.
REQ-009 SHALL have port fill_en  input  1  refill of one way completes this cycle.
REQ-010 SHALL have port fill_index  input  addr_width  set index of the refill.
REQ-011 SHALL have port fill_way  input  3  way number of the refill.
REQ-012 SHALL have port flush_req  input  1  request to re-initialise all PLRU state.
REQ-013 SHALL have port ready  output  1  block accepts lookups.
REQ-014 SHALL have port res_valid  output  1  one-cycle strobe: result outputs valid.
REQ-015 SHALL have port hit_any  output  1  lookup hit any way.
REQ-016 SHALL have port hit_way  output  3  encoded hit way.
REQ-017 SHALL have port victim_way  output  3  way to replace on miss.

Function
REQ-018 SHALL hold 2^addr_width PLRU rows of 7 bits; b0 is root (0 = ways 0-3, 1 = ways 4-7); b1 selects in 0-3 (0 = ways 0-1); b2 selects in 4-7 (0 = ways 4-5); b3..b6 select within pairs (0,1),(2,3),(4,5),(6,7) (0 = lower way).
REQ-019 SHALL implement two states: INIT and IDLE.
REQ-020 In INIT, SHALL clear one row per cycle, index 0 to 2^addr_width-1 ascending, then enter IDLE; ready=0 throughout INIT, 1 in IDLE.
REQ-021 In IDLE, flush_req=1 SHALL enter INIT the next cycle with the sweep counter at 0; flush_req in INIT SHALL be ignored.
REQ-022 lookup_valid while ready=0 SHALL be ignored: no result, no update.
REQ-023 On an accepted lookup at cycle T, SHALL latch the index and read the PLRU row into stage-1 registers by the end of T.
REQ-024 In T+1, SHALL combine the row with the hit/valid inputs and register the results; res_valid=1 with hit_any, hit_way and victim_way valid in T+2 only.
REQ-025 Back-to-back lookups, one per cycle, SHALL be supported with one result per cycle.
REQ-026 hit_any SHALL be the OR of hit[7:0]; hit_way SHALL be the lowest-numbered set bit of hit, or 0 when there is no hit.
REQ-027 victim_way SHALL be the lowest-numbered way with valid=0 if any exists; otherwise it SHALL be the way reached by walking the tree bits.
REQ-028 On hit_any in T+1, SHALL write that set's row so every tree bit on hit_way's path points away from hit_way; bits off the path are unchanged.
REQ-029 On fill_en, SHALL apply the same path update for fill_way at fill_index in that cycle.
REQ-030 Single write port: when fill_en and a hit update fall in the same cycle, the fill SHALL be written and the hit update dropped.
REQ-031 A row read in the same cycle as a write to the same index SHALL return the newly written value (write-first forwarding).
REQ-032 A lookup in the stage-1 register when flush_req is taken SHALL still produce its result in T+2, but its hit update SHALL be discarded.
REQ-033 fill_en SHALL be ignored in INIT.

Reset
REQ-034 rstn=0 SHALL asynchronously force state INIT, sweep counter 0, stage-1 valid 0, ready 0, res_valid 0, hit_any 0, hit_way 0, victim_way 0.
REQ-035 After rstn deasserts, ready SHALL rise after exactly 2^addr_width clk cycles (16 at default), with all rows 0.
REQ-036 Reset asserted mid-sweep or mid-lookup SHALL abort all activity and restart the sweep from index 0.

Verification
REQ-037 Reset release, no stimulus -> ready=0 for 16 cycles, then 1; no res_valid pulses.
REQ-038 Lookup idx 3, valid=8'hFF, hit=0, all rows 0 -> res_valid at T+2, hit_any=0, victim_way=0.
REQ-039 Lookup idx 3, valid=8'b1111_0111, hit=0 -> victim_way=3 regardless of the tree bits.
REQ-040 Lookup idx 5, hit=8'h01, then lookup idx 5 miss with valid=8'hFF -> first result hit_way=0, hit_any=1; second victim_way=4 (row = b0=1, b1=1, b3=1).
REQ-041 fill_en idx 2 way 6 in the same cycle as a hit update idx 7 way 1 -> row 2 updated; row 7 unchanged; a lookup of idx 2 in that cycle sees the new row.
REQ-042 flush_req with a lookup in stage 1 -> its result still emitted at T+2; ready=0 for 16 cycles; afterwards all rows read 0.

Source files
------------

// File: rtl/l2cache_plru_replace.sv
// Tree pseudo-LRU replacement for an 8-way L2: one 7-bit PLRU row per set, a two-stage
// lookup pipeline producing hit/victim results, and a power-up/flush sweep that clears every row.
module l2cache_plru_replace #(
    parameter int addr_width = 4,
    parameter int way        = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  lookup_valid,
    input  logic [addr_width-1:0] lookup_index,
    input  logic [way-1:0]        hit,
    input  logic [way-1:0]        valid,
    input  logic                  fill_en,
    input  logic [addr_width-1:0] fill_index,
    input  logic [2:0]            fill_way,
    input  logic                  flush_req,
    output logic                  ready,
    output logic                  res_valid,
    output logic                  hit_any,
    output logic [2:0]            hit_way,
    output logic [2:0]            victim_way
);

    localparam int SETS = 1 << addr_width;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t                state, state_nxt;
    logic [addr_width-1:0] cnt, cnt_nxt;

    logic [6:0]            plru_mem [SETS];

    logic                  we;
    logic [addr_width-1:0] widx;
    logic [6:0]            wdata;
    logic [6:0]            rd_row;

    logic                  vld_p1;
    logic [addr_width-1:0] idx_p1;
    logic [6:0]            row_p1;

    logic                  hit_any_c;
    logic [2:0]            hit_way_c;
    logic [2:0]            victim_c;

    // Lowest-numbered set bit, 0 when the vector is empty.
    function automatic logic [2:0] first_set(input logic [way-1:0] v);
        first_set = '0;
        for (int i = way - 1; i >= 0; i--) begin
            if (v[i]) begin
                first_set = 3'(i);
            end
        end
    endfunction

    function automatic logic [2:0] tree_walk(input logic [6:0] row);
        logic half;
        logic quad;
        logic leaf;
        half = row[0];
        quad = half ? row[2] : row[1];
        case ({half, quad})
            2'd0:    leaf = row[3];
            2'd1:    leaf = row[4];
            2'd2:    leaf = row[5];
            default: leaf = row[6];
        endcase
        tree_walk = {half, quad, leaf};
    endfunction

    // Point every node on the path to w away from w; nodes off the path keep their value.
    function automatic logic [6:0] path_update(input logic [6:0] row, input logic [2:0] w);
        path_update    = row;
        path_update[0] = ~w[2];
        if (w[2]) begin
            path_update[2] = ~w[1];
        end else begin
            path_update[1] = ~w[1];
        end
        case (w[2:1])
            2'd0:    path_update[3] = ~w[0];
            2'd1:    path_update[4] = ~w[0];
            2'd2:    path_update[5] = ~w[0];
            default: path_update[6] = ~w[0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Single write port: sweep clear in INIT; in IDLE a refill outranks the hit update,
    // and a hit update coinciding with an accepted flush is dropped.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        we        = 1'b0;
        widx      = '0;
        wdata     = '0;
        case (state)
            INIT: begin
                we      = 1'b1;
                widx    = cnt;
                wdata   = '0;
                cnt_nxt = cnt + addr_width'(1);
                if (&cnt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                ready = 1'b1;
                if (flush_req) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
                if (fill_en) begin
                    we    = 1'b1;
                    widx  = fill_index;
                    wdata = path_update(plru_mem[fill_index], fill_way);
                end else if (vld_p1 && hit_any_c && !flush_req) begin
                    we    = 1'b1;
                    widx  = idx_p1;
                    wdata = path_update(row_p1, hit_way_c);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            plru_mem[widx] <= wdata;
        end
    end

    // Write-first: a lookup of the row being written this cycle sees the new value.
    assign rd_row = (we && (widx == lookup_index)) ? wdata : plru_mem[lookup_index];

    // ---- stage 0 -> stage 1: accept lookup, capture index and row ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= lookup_valid && ready;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1 <= lookup_index;
        row_p1 <= rd_row;
    end

    assign hit_any_c = |hit;
    assign hit_way_c = first_set(hit);
    assign victim_c  = (&valid) ? tree_walk(row_p1) : first_set(~valid);

    // ---- stage 1 -> stage 2: register results ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid  <= 1'b0;
            hit_any    <= 1'b0;
            hit_way    <= '0;
            victim_way <= '0;
        end else begin
            res_valid <= vld_p1;
            if (vld_p1) begin
                hit_any    <= hit_any_c;
                hit_way    <= hit_way_c;
                victim_way <= victim_c;
            end
        end
    end

endmodule
